// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: op-codes, the packed
// command-entry layout held in the FIFO, and the control state type.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  // Entry layout, LSB first: chain(1) | b(8) | a(8) | op(3)
  localparam int ENTRY_W   = 20;
  localparam int CHAIN_LSB = 0;
  localparam int B_LSB     = 1;
  localparam int A_LSB     = 9;
  localparam int OP_LSB    = 17;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } seq_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       chain
  );
    return {op, a, b, chain};
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between an upstream initiator (master)
// and the ALU command sequencer (slave).
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
    output cmd_ready, res_valid, res_data, res_carry
  );
endinterface

// File: rtl/alu_cmd_sequencer_alu.sv
// Combinational 8-bit ALU datapath. Carry is always the add carry of the
// operands, independent of the selected operation.
module ALU
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       carry
);

  logic [8:0] sum;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign carry = sum[8];

  always_comb begin
    result = sum[7:0];
    case (op)
      OP_ADD:  result = sum[7:0];
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      default: result = sum[7:0];
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues one per cycle into the ALU and holds
// the registered result until the downstream handshake completes.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_sequencer_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               issue;
  logic [ENTRY_W-1:0] head;
  logic [2:0]         head_op;
  logic [7:0]         head_a;
  logic [7:0]         head_b;
  logic               head_chain;

  logic [7:0]         acc;
  logic [7:0]         alu_a;
  logic [7:0]         alu_result;
  logic               alu_carry;
  logic [7:0]         res_data_q;
  logic               res_carry_q;

  seq_state_t         state;
  seq_state_t         state_next;

  // Ready depends only on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign bus.cmd_ready = (count < FULL_COUNT);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign issue         = (count != '0) && ((state == ST_IDLE) || bus.res_ready);

  assign head       = fifo_mem[rd_ptr];
  assign head_op    = head[OP_LSB +: 3];
  assign head_a     = head[A_LSB +: 8];
  assign head_b     = head[B_LSB +: 8];
  assign head_chain = head[CHAIN_LSB];
  assign alu_a      = head_chain ? acc : head_a;

  ALU u_alu (
    .op     (head_op),
    .a      (alu_a),
    .b      (head_b),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= pack_entry(bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_chain);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HOLD persists across back-to-back issues; it only drops on a handshake
  // that finds nothing left to issue.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue) state_next = ST_HOLD;
      ST_HOLD: if (!issue && bus.res_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Result capture and accumulator load share the issue edge, so a chained
  // command issued next cycle already sees this result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q  <= 8'h00;
      res_carry_q <= 1'b0;
      acc         <= 8'h00;
    end else if (issue) begin
      res_data_q  <= alu_result;
      res_carry_q <= alu_carry;
      acc         <= alu_result;
    end
  end

  assign bus.res_valid = (state == ST_HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign fifo_count    = count;
  assign busy          = (count != '0) || bus.res_valid;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side front end for the team's 8-bit ALU datapath. Buffers operation requests from an upstream initiator in a small FIFO, issues one per cycle to an instance of the combinational ALU, and returns registered result plus carry through a valid/ready handshake. Optional chaining substitutes the previous result for operand A, so multi-step expressions run without an upstream round trip.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_op  in  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nand, 6 nor, 7 xnor
- cmd_a  in  8  operand A (ignored when cmd_chain=1)
- cmd_b  in  8  operand B
- cmd_chain  in  1  use accumulator as operand A
- res_valid  out  1  result held
- res_ready  in  1  downstream accepts result
- res_data  out  8  result, modulo 256
- res_carry  out  1  bit 8 of {0,A}+{0,B} for the issued operands, regardless of op
- fifo_count  out  $clog2(DEPTH)+1  entries queued
- busy  out  1  fifo_count≠0 or res_valid

## Operation
- Push: cmd_valid && cmd_ready at an edge writes {op,a,b,chain} to FIFO tail. cmd_ready = (fifo_count < DEPTH), from registered count only; no push while full even if a pop occurs the same cycle.
- Issue condition: FIFO non-empty && (!res_valid || res_ready). On issue: pop head, drive ALU with op, A = chain ? acc : a, B = b; capture ALU output into res_data, carry into res_carry, set res_valid, and load acc with the same result — all at one edge.
- No issue and res_valid && res_ready: res_valid clears.
- Output stable while res_valid && !res_ready (no change to res_data/res_carry/acc).
- Accumulator: 8-bit, reset 0, updates only on issue. Chained command issued back-to-back sees the immediately preceding result (no hazard: capture and acc load coincide).
- No FIFO bypass: a command pushed into an empty FIFO issues no earlier than the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Effective two-state control: IDLE (res_valid=0) and HOLD (res_valid=1); HOLD→HOLD on issue, HOLD→IDLE on handshake with empty FIFO, IDLE→HOLD on issue.

## Timing
- Reset (async assert, sync-safe release): res_valid 0, res_data 0x00, res_carry 0, acc 0x00, fifo_count 0, cmd_ready 1, busy 0; FIFO contents discarded. Reset mid-operation drops all queued and held results.
- Latency: cmd handshake at edge N → res_valid high after edge N+1.
- Throughput: one result per cycle with res_ready held high.
- Backpressure: with res_ready low, DEPTH commands queue, then cmd_ready drops; total in flight DEPTH+1.

## Structure
- Package alu_seq_pkg: op-code localparams (OP_ADD..OP_XNOR), command entry width (20 bits: op 3, a 8, b 8, chain 1), field offsets.
- One sub-module: the existing combinational ALU (module ALU) instanced as the datapath; FIFO, accumulator and output register inline.

## Test plan
- Reset: assert rst_n=0 mid-burst with 3 queued → all outputs at reset values immediately; after release first new command add 0x10+0x20 returns 0x30, carry 0.
- Carry/wrap: add 0xF0+0x20 → res_data 0x10, res_carry 1; sub 0x05−0x07 → 0xFE, carry 0; and 0xFF,0xFF → 0xFF, carry 1.
- Chain: add 0x01+0x02, then chain xor B=0x0F, then chain nand B=0xF0 back-to-back → 0x03, 0x0C, 0xFF.
- Full FIFO: res_ready=0, push 5 commands (DEPTH=4) → 1 held, fifo_count 4, cmd_ready 0; 6th not accepted; release res_ready → 5 results in order, one per cycle.
- Simultaneous push/pop at count 2 with res_ready=1 → count stays 2 for continuous streaming; 8 commands all ops return correct values in order.
- Latency: single command at idle → res_valid exactly one cycle after acceptance cycle; busy falls the cycle after result handshake.
